bin2bcd_seq: RTL and testbench

- Sequential binary-to-BCD converter (shift-add-3, "double dabble") sitting directly downstream of the 32-bit unsigned divider in the calculator datapath.
- Takes the registered quotient and produces packed BCD digits plus a significant-digit count for the display/formatter stage.
- Uses a valid/ready handshake on both sides and converts one bit per clock.

---
 rtl/calc_pkg.sv | 26 ++
 rtl/bin2bcd_seq_if.sv | 26 ++
 rtl/bcd_digit_adj.sv | 10 +
 rtl/bin2bcd_seq.sv | 82 ++++++++
 tb/tb_bin2bcd_seq.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// Shared calculator datapath definitions: BCD digit sizing, converter states
// and the significant-digit counting helper used by the formatter path.
package calc_pkg;

   localparam int BCD_W          = 4;
   localparam int DEFAULT_DIGITS = 10;
   // num_digits is 4 bits wide, so no converter can exceed 15 digits.
   localparam int MAX_DIGITS     = 15;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } bcd_state_t;

   // Highest nonzero digit index plus one; an all-zero value still shows one digit.
   function automatic logic [3:0] bcd_digit_count(input logic [BCD_W*MAX_DIGITS-1:0] bcd);
      logic [3:0] cnt;
      cnt = 4'd1;
      for (int i = 0; i < MAX_DIGITS; i++) begin
         if (bcd[BCD_W*i +: BCD_W] != '0) cnt = 4'(i + 1);
      end
      return cnt;
   endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Handshake bundle between the divider result, the BCD converter and the formatter.
interface bin2bcd_seq_if import calc_pkg::*; #(
   parameter int N      = 32,
   parameter int DIGITS = DEFAULT_DIGITS
) ();

   logic                      in_valid;
   logic                      in_ready;
   logic [N-1:0]              bin_in;
   logic                      out_valid;
   logic                      out_ready;
   logic [BCD_W*DIGITS-1:0]   bcd_out;
   logic [3:0]                num_digits;
   logic                      ovf;

   modport master (
      output in_valid, bin_in, out_ready,
      input  in_ready, out_valid, bcd_out, num_digits, ovf
   );

   modport slave (
      input  in_valid, bin_in, out_ready,
      output in_ready, out_valid, bcd_out, num_digits, ovf
   );

endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a digit of 5 or more gets 3 added before the shift.
module bcd_digit_adj import calc_pkg::*; (
   input  logic [BCD_W-1:0] din,
   output logic [BCD_W-1:0] dout
);

   // No carry out: a valid digit (0..9) plus 3 never exceeds 12.
   assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one shift-add-3 step per clock,
// valid/ready on both sides; sits after the 32-bit divider.
module bin2bcd_seq import calc_pkg::*; #(
   parameter int N      = 32,
   parameter int DIGITS = DEFAULT_DIGITS,
   parameter int CW     = 6
) (
   input  logic         clk,
   input  logic         rst_n,
   bin2bcd_seq_if.slave bus
);

   localparam int BW = BCD_W * DIGITS;

   localparam logic [1:0] S_IDLE  = 2'(IDLE);
   localparam logic [1:0] S_SHIFT = 2'(SHIFT);
   localparam logic [1:0] S_DONE  = 2'(DONE);

   logic [1:0]                    state;
   logic [N-1:0]                  bin_q;
   logic [BW-1:0]                 bcd_q;
   logic [BW-1:0]                 bcd_adj;
   logic [CW-1:0]                 cnt_q;
   logic                          ovf_q;
   logic [BCD_W*MAX_DIGITS-1:0]   bcd_ext;

   for (genvar d = 0; d < DIGITS; d++) begin : g_adj
      bcd_digit_adj u_adj (
         .din  (bcd_q  [BCD_W*d +: BCD_W]),
         .dout (bcd_adj[BCD_W*d +: BCD_W])
      );
   end

   // NOTE: state uses non-blocking assignments so every register samples the
   // pre-edge values of the others; blocking here would chain the shift within one edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         bin_q <= '0;
         bcd_q <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  bin_q <= bus.bin_in;
                  bcd_q <= '0;
                  ovf_q <= 1'b0;
                  cnt_q <= CW'(N - 1);
                  state <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               // {BCD, binary} << 1 after correction; the bit leaving the top digit is lost.
               bcd_q <= {bcd_adj[BW-2:0], bin_q[N-1]};
               bin_q <= {bin_q[N-2:0], 1'b0};
               ovf_q <= ovf_q | bcd_adj[BW-1];
               if (cnt_q == '0) state <= S_DONE;
               else             cnt_q <= cnt_q - CW'(1);
            end
            S_DONE: begin
               if (bus.out_ready) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // NOTE: always_comb gives every output a default first so no latch is inferred.
   always_comb begin
      bcd_ext         = '0;
      bcd_ext[BW-1:0] = bcd_q;
   end

   assign bus.in_ready   = (state == S_IDLE);
   assign bus.out_valid  = (state == S_DONE);
   assign bus.bcd_out    = bcd_q;
   assign bus.ovf        = ovf_q;
   assign bus.num_digits = bcd_digit_count(bcd_ext);

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: vector table plus scoreboard, with
// backpressure, reset and handshake-collision sequences; a 9-digit instance covers overflow.
module tb_bin2bcd_seq;

   typedef struct {
      logic [31:0] bin;
      logic [39:0] bcd;
      logic [3:0]  nd;
      logic        ovf;
   } vec_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   n_checks = 0;
   int   n_pass   = 0;
   vec_t sb[$];
   vec_t vecs[7];

   bin2bcd_seq_if #(.N(32), .DIGITS(10)) a_if ();
   bin2bcd_seq_if #(.N(32), .DIGITS(9))  b_if ();

   bin2bcd_seq #(.N(32), .DIGITS(10), .CW(6)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (a_if.slave)
   );

   bin2bcd_seq #(.N(32), .DIGITS(9), .CW(6)) u_dut9 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b_if.slave)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic drive_in(input int w, input logic v, input logic [31:0] val);
      if (w == 0) begin a_if.in_valid = v; a_if.bin_in = val; end
      else        begin b_if.in_valid = v; b_if.bin_in = val; end
   endtask

   task automatic set_oready(input int w, input logic v);
      if (w == 0) a_if.out_ready = v;
      else        b_if.out_ready = v;
   endtask

   function automatic logic get_ready(input int w);
      return (w == 0) ? a_if.in_ready : b_if.in_ready;
   endfunction

   function automatic logic get_ovalid(input int w);
      return (w == 0) ? a_if.out_valid : b_if.out_valid;
   endfunction

   function automatic logic [39:0] get_bcd(input int w);
      return (w == 0) ? a_if.bcd_out : {4'h0, b_if.bcd_out};
   endfunction

   function automatic logic [3:0] get_nd(input int w);
      return (w == 0) ? a_if.num_digits : b_if.num_digits;
   endfunction

   function automatic logic get_ovf(input int w);
      return (w == 0) ? a_if.ovf : b_if.ovf;
   endfunction

   // Waits for in_ready, presents one value and returns #1 after the accepting edge.
   task automatic send(input int w, input vec_t v);
      int guard = 0;
      while (!get_ready(w) && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 100) check("in_ready_timeout", 0, 1);
      drive_in(w, 1'b1, v.bin);
      sb.push_back(v);
      @(posedge clk);
      #1;
      drive_in(w, 1'b0, '0);
   endtask

   // Called #1 after the accepting edge; counts edges until out_valid and scores the result.
   task automatic wait_result(input int w, input string tag);
      int   lat = 0;
      vec_t e;
      while (!get_ovalid(w) && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check({tag, "_latency"}, 64'(lat), 64'd32);
      if (sb.size() == 0) begin
         check({tag, "_sb_empty"}, 0, 1);
      end else begin
         e = sb.pop_front();
         check({tag, "_bcd"}, get_bcd(w), e.bcd);
         check({tag, "_nd"},  get_nd(w),  e.nd);
         check({tag, "_ovf"}, get_ovf(w), e.ovf);
      end
   endtask

   task automatic handshake(input int w, input string tag);
      set_oready(w, 1'b1);
      @(posedge clk);
      #1;
      set_oready(w, 1'b0);
      check({tag, "_ov_drop"}, get_ovalid(w), 0);
   endtask

   initial begin
      logic stable;

      vecs[0] = '{32'd0,          40'h0000000000, 4'd1,  1'b0};
      vecs[1] = '{32'd10,         40'h0000000010, 4'd2,  1'b0};
      vecs[2] = '{32'd51,         40'h0000000051, 4'd2,  1'b0};
      vecs[3] = '{32'hFFFF_FFFF,  40'h4294967295, 4'd10, 1'b0};
      vecs[4] = '{32'd12345678,   40'h0012345678, 4'd8,  1'b0};
      vecs[5] = '{32'd100,        40'h0000000100, 4'd3,  1'b0};
      vecs[6] = '{32'd1000000000, 40'h1000000000, 4'd10, 1'b0};

      drive_in(0, 1'b0, '0);
      drive_in(1, 1'b0, '0);
      set_oready(0, 1'b0);
      set_oready(1, 1'b0);

      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready",  a_if.in_ready,   1);
      check("rst_out_valid", a_if.out_valid,  0);
      check("rst_bcd",       a_if.bcd_out,    0);
      check("rst_ovf",       a_if.ovf,        0);
      check("rst_nd",        a_if.num_digits, 1);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 7; i++) begin
         send(0, vecs[i]);
         wait_result(0, $sformatf("vec%0d", i));
         handshake(0, $sformatf("vec%0d", i));
      end

      // Backpressure: result held while out_ready stays low, new input ignored.
      send(0, '{32'd5, 40'h5, 4'd1, 1'b0});
      wait_result(0, "bp5");
      stable = 1'b1;
      for (int c = 0; c < 7; c++) begin
         drive_in(0, c[0], 32'd99);
         @(posedge clk);
         #1;
         if (!a_if.out_valid || a_if.bcd_out != 40'h5 || a_if.in_ready) stable = 1'b0;
      end
      drive_in(0, 1'b0, '0);
      check("bp_stable", stable, 1);
      handshake(0, "bp5");
      send(0, '{32'd99, 40'h99, 4'd2, 1'b0});
      wait_result(0, "bp99");
      handshake(0, "bp99");

      // Handshake and new input in the same DONE cycle: accepted only from IDLE.
      send(0, '{32'd7, 40'h7, 4'd1, 1'b0});
      wait_result(0, "coll7");
      set_oready(0, 1'b1);
      drive_in(0, 1'b1, 32'd123);
      @(posedge clk);
      #1;
      check("coll_idle_ready", a_if.in_ready,  1);
      check("coll_idle_ov",    a_if.out_valid, 0);
      set_oready(0, 1'b0);
      @(posedge clk);
      #1;
      drive_in(0, 1'b0, '0);
      check("coll_accepted", a_if.in_ready, 0);
      sb.push_back('{32'd123, 40'h123, 4'd3, 1'b0});
      wait_result(0, "coll123");
      handshake(0, "coll123");

      // Reset mid-conversion discards the partial result.
      send(0, '{32'd12345, 40'h12345, 4'd5, 1'b0});
      repeat (10) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("mid_rst_ov",    a_if.out_valid, 0);
      check("mid_rst_bcd",   a_if.bcd_out,   0);
      check("mid_rst_ready", a_if.in_ready,  1);
      sb.delete();
      stable = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
         if (a_if.out_valid) stable = 1'b0;
      end
      check("mid_rst_no_ov", stable, 1);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("post_rst_ready", a_if.in_ready, 1);
      send(0, '{32'd7, 40'h7, 4'd1, 1'b0});
      wait_result(0, "post_rst7");
      handshake(0, "post_rst7");

      // Nine-digit instance: overflow detection and a full-width in-range value.
      send(1, '{32'd1000000000, 40'h000000000, 4'd1, 1'b1});
      wait_result(1, "d9_ovf");
      handshake(1, "d9_ovf");
      send(1, '{32'd999999999, 40'h999999999, 4'd9, 1'b0});
      wait_result(1, "d9_max");
      handshake(1, "d9_max");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
